// File: rtl/fdiv_iter_5_3.sv
// Iterative divider for the 11-bit (wE=5, wF=3) float format.
// Restoring significand division, one quotient bit per cycle, with a valid/ready handshake.
module fdiv_iter_5_3 #(
  parameter int ID   = 1,
  parameter int WE   = 5,
  parameter int WF   = 3,
  parameter int BIAS = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WE+WF+2:0]     X,
  input  logic [WE+WF+2:0]     Y,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WE+WF+2:0]     R,
  output logic                 out_valid,
  input  logic                 out_ready
);

  if (WE != 32'sd5 || WF != 32'sd3 || BIAS != 32'sd15 || ID < 32'sd0) begin : g_cfg_check
    $error("fdiv_iter_5_3: only WE=5, WF=3, BIAS=15 supported");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;

  state_t      state_r, state_s;
  logic        sign_r, sign_s;
  logic [4:0]  exp_x_r, exp_x_s, exp_y_r, exp_y_s;
  logic [3:0]  sig_y_r, sig_y_s;
  logic [4:0]  rem_r, rem_s;
  logic [5:0]  q_r, q_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [10:0] res_r, res_s;
  logic        in_ready_r, out_valid_r;

  logic        ge_s, norm_s, guard_s, sticky_s, inc_s;
  logic [4:0]  rem_sel_s;
  logic [2:0]  frac_s;
  logic [3:0]  frac_rnd_s;
  logic [6:0]  e_base_s, e_fin_s;

  // Special-operand result class; NaN and indeterminate forms win over inf/zero.
  function automatic logic [1:0] exc_result(input logic [1:0] ex, input logic [1:0] ey);
    logic [1:0] r;
    if (ex == 2'b11 || ey == 2'b11) r = 2'b11;
    else if ((ex == 2'b00 && ey == 2'b00) || (ex == 2'b10 && ey == 2'b10)) r = 2'b11;
    else if (ex == 2'b10 || ey == 2'b00) r = 2'b10;
    else r = 2'b00;
    return r;
  endfunction

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign R         = res_r;

  // Next-state, division step and rounding logic
  always_comb begin
    state_s   = state_r;
    sign_s    = sign_r;
    exp_x_s   = exp_x_r;
    exp_y_s   = exp_y_r;
    sig_y_s   = sig_y_r;
    rem_s     = rem_r;
    q_s       = q_r;
    cnt_s     = cnt_r;
    res_s     = res_r;

    ge_s      = (rem_r >= {1'b0, sig_y_r});
    if (ge_s) rem_sel_s = rem_r - {1'b0, sig_y_r};
    else      rem_sel_s = rem_r;

    norm_s    = q_r[5];
    if (norm_s) begin
      frac_s  = q_r[4:2];
      guard_s = q_r[1];
    end else begin
      frac_s  = q_r[3:1];
      guard_s = q_r[0];
    end
    sticky_s   = (norm_s & q_r[0]) | (rem_r != 5'd0);
    inc_s      = guard_s & (sticky_s | frac_s[0]);
    frac_rnd_s = {1'b0, frac_s} + {3'd0, inc_s};
    // Seven-bit two's complement exponent: expX - expY + bias, one less when unnormalised
    e_base_s   = {2'b00, exp_x_r} - {2'b00, exp_y_r} + 7'(BIAS) - {6'd0, ~norm_s};
    e_fin_s    = e_base_s + {6'd0, frac_rnd_s[3]};

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          sign_s  = X[8] ^ Y[8];
          exp_x_s = X[7:3];
          exp_y_s = Y[7:3];
          sig_y_s = {1'b1, Y[2:0]};
          q_s     = 6'd0;
          cnt_s   = 3'd5;
          if (X[10:9] != 2'b01 || Y[10:9] != 2'b01) begin
            rem_s   = 5'd0;
            res_s   = {exc_result(X[10:9], Y[10:9]), X[8] ^ Y[8], 8'h00};
            state_s = DONE;
          end else begin
            rem_s   = {2'b01, X[2:0]};
            state_s = DIV;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DIV: begin
        q_s[cnt_r] = ge_s;
        rem_s      = rem_sel_s << 1;
        if (cnt_r == 3'd0) begin
          state_s = ROUND;
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      ROUND: begin
        if (e_fin_s[6]) begin
          res_s = {2'b00, sign_r, 8'h00};
        end else if (e_fin_s[5]) begin
          res_s = {2'b10, sign_r, 8'h00};
        end else begin
          res_s = {2'b01, sign_r, e_fin_s[4:0], frac_rnd_s[2:0]};
        end
        state_s = DONE;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sign_r      <= 1'b0;
      exp_x_r     <= 5'd0;
      exp_y_r     <= 5'd0;
      sig_y_r     <= 4'd0;
      rem_r       <= 5'd0;
      q_r         <= 6'd0;
      cnt_r       <= 3'd0;
      res_r       <= 11'h000;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      sign_r      <= sign_s;
      exp_x_r     <= exp_x_s;
      exp_y_r     <= exp_y_s;
      sig_y_r     <= sig_y_s;
      rem_r       <= rem_s;
      q_r         <= q_s;
      cnt_r       <= cnt_s;
      res_r       <= res_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

endmodule

// File: doc/fdiv_iter_5_3.md
Name: fdiv_iter_5_3

Overview:
- Iterative floating-point divider R = X / Y for the 11-bit FloPoCo-style format (wE=5, wF=3) consumed and produced by the fmul_5_3 datapath.
- Inverse operation to the multiplier: restoring division of significands, one quotient bit per cycle.
- Valid/ready handshakes on input and output, for sharing in the HLS operator pool where divides are rare.

Parameters:
- ID, 1, instance tag; no functional effect.
- WE, 5, exponent width; fixed, only 5 supported.
- WF, 3, fraction width; fixed, only 3 supported.
- BIAS, 15, exponent bias.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- X  in  11  dividend: [10:9] exc (00 zero, 01 normal, 10 inf, 11 NaN), [8] sign, [7:3] biased exponent, [2:0] fraction
- Y  in  11  divisor, same format
- in_valid  in  1  X/Y valid
- in_ready  out  1  divider idle, can accept
- R  out  11  quotient, same format
- out_valid  out  1  R valid
- out_ready  in  1  consumer accepts R

Behaviour:
- Reset: rst_n sampled low at a clk edge forces state IDLE, out_valid=0, R=11'h000, quotient/remainder/counter cleared.
- Reset mid-operation aborts the division. The result is discarded and never presented.
- FSM states: IDLE, DIV, ROUND, DONE.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- Accept occurs when in_valid & in_ready at an edge (cycle 0). X and Y are registered.
- Sign = X[8]^Y[8] for every result, including NaN/zero/inf.
- Exception path (any operand exc != 01) goes IDLE -> DONE, so out_valid is high from cycle 1:
  - Either NaN, 0/0, or inf/inf: exc=11.
  - inf/(zero|normal), or normal/zero: exc=10.
  - zero/(normal|inf), or normal/inf: exc=00.
  - Exponent and fraction fields are 0 on this path.
- Normal path:
  - sigX={1,X[2:0]}, sigY={1,Y[2:0]}. Remainder is 5 bits, initialised to sigX.
  - DIV runs exactly 6 cycles (cycles 1-6) with a counter 5 down to 0.
  - Each DIV cycle: if rem >= sigY then q[cnt]=1 and rem -= sigY, else q[cnt]=0; then rem <<= 1.
  - ROUND is cycle 7. out_valid is high from cycle 8.
  - Normalisation when q5=1: frac=q4..q2, guard=q1, sticky=q0|(rem!=0), e = expX - expY + 15.
  - Normalisation when q5=0: frac=q3..q1, guard=q0, sticky=(rem!=0), e = expX - expY + 14.
  - Round to nearest even: increment when guard & (sticky | frac[0]).
  - If frac wraps 111 -> 000 on increment, e += 1.
  - e is computed as 7-bit signed.
  - 0 <= e <= 31: exc=01.
  - e > 31: exc=10, exponent and fraction zero.
  - e < 0: exc=00, flush to zero, no subnormals.
- Output handshake:
  - R and out_valid are held stable in DONE until out_ready.
  - DONE & out_ready at an edge -> IDLE. in_ready rises the following cycle.
  - There is no overlap between consecutive operations.
- in_valid while busy is ignored. The producer must hold X/Y until accepted.
- out_ready asserted outside DONE has no effect.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, R=0x000, in_ready=1 after release, no spurious result.
- Exact normal divide: 1.5/1.0, X=0x27C, Y=0x278, accepted at cycle 0 -> out_valid first high at cycle 8, R=0x27C. Then -1.5/1.0, X=0x37C -> R=0x37C.
- Normalisation and rounding: 1.0/1.5, X=0x278, Y=0x27C -> q=010101, rem!=0, round up -> R=0x273 (0.6875).
- Range limits:
  - Overflow: X=0x2F8 (exp 31) / Y=0x200 (exp 0) -> R=0x400 (inf).
  - Underflow: X=0x200 / Y=0x2F8 -> R=0x000.
  - Both take 8 cycles.
- Exceptions: 0/0 (0x000/0x000) -> R=0x600 at cycle 1. Then 0x278/0x000 -> R=0x400. Then 0x000/0x278 -> R=0x000. Then inf/inf (0x400/0x400) -> R=0x600.
- Backpressure and abort:
  - Hold out_ready=0 for 5 cycles in DONE -> R and out_valid stable, in_ready=0.
  - Second request presented during DIV is not accepted until after the DONE handshake.
  - rst_n=0 at cycle 4 of a divide -> no out_valid, back to IDLE.
